// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the writeback stage
package wb_pkg;
  localparam int CTL_W = 9;
  localparam int CTL_LD_GPR1 = 8;
  localparam int CTL_LD_GPR2 = 7;
  localparam int CTL_LD_GPR3 = 6;
  localparam int CTL_LD_SEG = 5;
  localparam int CTL_LD_MM = 4;
  localparam int CTL_DCACHE_WRITE = 3;
  localparam int CTL_LD_FLAGS = 2;
  localparam int CTL_DE_REPNE = 1;
  localparam int CTL_IS_CMPS_SECOND = 0;
  localparam int ZF_BIT = 6;
  localparam logic [31:0] FLAGS_RESET = 32'h0000_0002;
  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} wb_state_e;
endpackage

// File: rtl/wb_store_fsm.sv
// wb_store_fsm: data-cache store handshake sequencing and stage stall
module wb_store_fsm
  import wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic v,
  input  logic store,
  input  logic ack,
  output logic req,
  output logic stall
);
  wb_state_e state, state_n;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb
    state_n = (state == IDLE) ? ((req && !ack) ? WAIT_ACK : IDLE)
                              : ((ack || !req) ? IDLE : WAIT_ACK);
  always_comb begin
    req = !rst && v && (store || state == WAIT_ACK);
    stall = req && !ack;
  end
endmodule

// File: rtl/writeback_stage_wb.sv
// writeback_stage_wb: WB latches, retirement strobes, EFLAGS and store handshake
module writeback_stage_wb
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MM_W = 64,
  parameter int REG_ID_W = 3,
  parameter logic [DATA_W-1:0] FLAGS_RESET = wb_pkg::FLAGS_RESET
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  WB_ld_latches,
  input  logic                  WB_V_next,
  input  logic [DATA_W-1:0]     WB_RESULT_A_next,
  input  logic [DATA_W-1:0]     WB_RESULT_B_next,
  input  logic [DATA_W-1:0]     WB_RESULT_C_next,
  input  logic [DATA_W-1:0]     WB_FLAGS_next,
  input  logic [MM_W-1:0]       WB_RESULT_MM_next,
  input  logic [CTL_W-1:0]      WB_ctl_next,
  input  logic [3*REG_ID_W-1:0] WB_ids_next,
  input  logic [DATA_W-1:0]     WB_mem_addr_next,
  input  logic                  dcache_wr_ack,
  output logic                  WB_Stall,
  output logic                  wb_repne_terminate_all,
  output logic [DATA_W-1:0]     count_dataforwarded,
  output logic [DATA_W-1:0]     flags_dataforwarded,
  output logic [2:0]            gpr_we,
  output logic [3*REG_ID_W-1:0] gpr_id,
  output logic [3*DATA_W-1:0]   gpr_data,
  output logic                  seg_we,
  output logic                  mm_we,
  output logic [MM_W-1:0]       mm_data,
  output logic                  dcache_wr_req,
  output logic [DATA_W-1:0]     dcache_wr_addr,
  output logic [DATA_W-1:0]     dcache_wr_data,
  output logic [DATA_W-1:0]     eflags,
  output logic [31:0]           retired_count
);
  logic                  wb_v;
  logic [DATA_W-1:0]     wb_a, wb_b, wb_c, wb_flags, wb_addr;
  logic [MM_W-1:0]       wb_mm;
  logic [CTL_W-1:0]      wb_ctl;
  logic [3*REG_ID_W-1:0] wb_ids;
  logic                  active, retire;
  always_ff @(posedge CLK)
    if (CLR) begin
      wb_v <= 1'b0;
      wb_a <= '0;
      wb_b <= '0;
      wb_c <= '0;
      wb_flags <= '0;
      wb_mm <= '0;
      wb_ctl <= '0;
      wb_ids <= '0;
      wb_addr <= '0;
    end else if (WB_ld_latches) begin
      wb_v <= WB_V_next;
      wb_a <= WB_RESULT_A_next;
      wb_b <= WB_RESULT_B_next;
      wb_c <= WB_RESULT_C_next;
      wb_flags <= WB_FLAGS_next;
      wb_mm <= WB_RESULT_MM_next;
      wb_ctl <= WB_ctl_next;
      wb_ids <= WB_ids_next;
      wb_addr <= WB_mem_addr_next;
    end
  wb_store_fsm u_store (
    .clk  (CLK),
    .rst  (CLR),
    .v    (wb_v),
    .store(wb_ctl[CTL_DCACHE_WRITE]),
    .ack  (dcache_wr_ack),
    .req  (dcache_wr_req),
    .stall(WB_Stall)
  );
  always_comb begin
    active = wb_v && !CLR;
    retire = active && !WB_Stall;
    gpr_we = {3{retire}} & {wb_ctl[CTL_LD_GPR3], wb_ctl[CTL_LD_GPR2], wb_ctl[CTL_LD_GPR1]};
    seg_we = retire && wb_ctl[CTL_LD_SEG];
    mm_we = retire && wb_ctl[CTL_LD_MM];
    wb_repne_terminate_all = active && wb_ctl[CTL_DE_REPNE] && wb_ctl[CTL_IS_CMPS_SECOND]
                             && (wb_c == '0 || wb_flags[ZF_BIT]);
    flags_dataforwarded = (wb_v && wb_ctl[CTL_LD_FLAGS]) ? wb_flags : eflags;
    count_dataforwarded = wb_c;
    gpr_id = wb_ids;
    gpr_data = {wb_a, wb_b, wb_c};
    mm_data = wb_mm;
    dcache_wr_addr = wb_addr;
    dcache_wr_data = wb_a;
  end
  always_ff @(posedge CLK)
    if (CLR) begin
      eflags <= FLAGS_RESET;
      retired_count <= '0;
    end else if (retire) begin
      if (wb_ctl[CTL_LD_FLAGS]) eflags <= wb_flags;
      retired_count <= retired_count + 32'd1;
    end
endmodule

// File: tb/tb_writeback_stage_wb.sv
// tb_writeback_stage_wb: directed vectors with a queue-based scoreboard and decoupled monitor
module tb_writeback_stage_wb;
  import wb_pkg::*;
  typedef struct {
    logic        v;
    logic [8:0]  ctl;
    logic [8:0]  ids;
    logic [31:0] a, b, c, flags, addr;
    logic [63:0] mm;
    int          dly;
    logic [2:0]  exp_we;
    logic        exp_term;
  } vec_t;

  logic CLK, CLR, WB_ld_latches, WB_V_next, dcache_wr_ack;
  logic [31:0] WB_RESULT_A_next, WB_RESULT_B_next, WB_RESULT_C_next, WB_FLAGS_next, WB_mem_addr_next;
  logic [63:0] WB_RESULT_MM_next;
  logic [8:0] WB_ctl_next, WB_ids_next;
  logic WB_Stall, wb_repne_terminate_all, seg_we, mm_we, dcache_wr_req;
  logic [31:0] count_dataforwarded, flags_dataforwarded, dcache_wr_addr, dcache_wr_data, eflags, retired_count;
  logic [2:0] gpr_we;
  logic [8:0] gpr_id;
  logic [95:0] gpr_data;
  logic [63:0] mm_data;

  writeback_stage_wb dut (
    .CLK(CLK), .CLR(CLR), .WB_ld_latches(WB_ld_latches), .WB_V_next(WB_V_next),
    .WB_RESULT_A_next(WB_RESULT_A_next), .WB_RESULT_B_next(WB_RESULT_B_next),
    .WB_RESULT_C_next(WB_RESULT_C_next), .WB_FLAGS_next(WB_FLAGS_next),
    .WB_RESULT_MM_next(WB_RESULT_MM_next), .WB_ctl_next(WB_ctl_next), .WB_ids_next(WB_ids_next),
    .WB_mem_addr_next(WB_mem_addr_next), .dcache_wr_ack(dcache_wr_ack), .WB_Stall(WB_Stall),
    .wb_repne_terminate_all(wb_repne_terminate_all), .count_dataforwarded(count_dataforwarded),
    .flags_dataforwarded(flags_dataforwarded), .gpr_we(gpr_we), .gpr_id(gpr_id), .gpr_data(gpr_data),
    .seg_we(seg_we), .mm_we(mm_we), .mm_data(mm_data), .dcache_wr_req(dcache_wr_req),
    .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data), .eflags(eflags),
    .retired_count(retired_count)
  );

  assign WB_ld_latches = ~WB_Stall;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  vec_t sb[$];
  vec_t vecs[$];
  int dq[$];
  vec_t bub, r;
  logic mon_en = 1'b0;
  logic [31:0] m_eflags, m_cnt;
  int st_cnt = 0;
  logic st;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic v, logic [8:0] ctl, logic [8:0] ids, logic [31:0] a, logic [31:0] b,
                              logic [31:0] c, logic [31:0] flags, logic [31:0] addr, logic [63:0] mm,
                              int dly, logic [2:0] we, logic term);
    vec_t x;
    x.v = v; x.ctl = ctl; x.ids = ids; x.a = a; x.b = b; x.c = c; x.flags = flags;
    x.addr = addr; x.mm = mm; x.dly = dly; x.exp_we = we; x.exp_term = term;
    return x;
  endfunction

  task automatic apply(vec_t x);
    WB_V_next = x.v; WB_ctl_next = x.ctl; WB_ids_next = x.ids;
    WB_RESULT_A_next = x.a; WB_RESULT_B_next = x.b; WB_RESULT_C_next = x.c;
    WB_FLAGS_next = x.flags; WB_mem_addr_next = x.addr; WB_RESULT_MM_next = x.mm;
  endtask

  always @(negedge CLK) if (mon_en) begin
    #2;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_underflow: got empty queue expected pending record at %0t", $time);
    end else if (WB_Stall) begin
      r = sb[0];
      st_cnt++;
      chk("stall_req", {63'd0, dcache_wr_req}, 64'd1);
      chk("stall_addr", {32'd0, dcache_wr_addr}, {32'd0, r.addr});
      chk("stall_data", {32'd0, dcache_wr_data}, {32'd0, r.a});
      chk("stall_gpr_we", {61'd0, gpr_we}, 64'd0);
      chk("stall_seg_mm", {62'd0, seg_we, mm_we}, 64'd0);
    end else begin
      r = sb.pop_front();
      chk("eflags", {32'd0, eflags}, {32'd0, m_eflags});
      chk("retired", {32'd0, retired_count}, {32'd0, m_cnt});
      chk("gpr_we", {61'd0, gpr_we}, {61'd0, r.exp_we});
      chk("gpr_id", {55'd0, gpr_id}, {55'd0, r.ids});
      chk("gpr_a", {32'd0, gpr_data[95:64]}, {32'd0, r.a});
      chk("gpr_b", {32'd0, gpr_data[63:32]}, {32'd0, r.b});
      chk("gpr_c", {32'd0, gpr_data[31:0]}, {32'd0, r.c});
      chk("count_fwd", {32'd0, count_dataforwarded}, {32'd0, r.c});
      chk("seg_we", {63'd0, seg_we}, {63'd0, r.v & r.ctl[CTL_LD_SEG]});
      chk("mm_we", {63'd0, mm_we}, {63'd0, r.v & r.ctl[CTL_LD_MM]});
      chk("mm_data", mm_data, r.mm);
      chk("terminate", {63'd0, wb_repne_terminate_all}, {63'd0, r.exp_term});
      chk("flags_fwd", {32'd0, flags_dataforwarded},
          {32'd0, (r.v && r.ctl[CTL_LD_FLAGS]) ? r.flags : m_eflags});
      st = r.v && r.ctl[CTL_DCACHE_WRITE];
      chk("req", {63'd0, dcache_wr_req}, {63'd0, st});
      if (st) begin
        chk("st_addr", {32'd0, dcache_wr_addr}, {32'd0, r.addr});
        chk("st_data", {32'd0, dcache_wr_data}, {32'd0, r.a});
        chk("stall_cycles", st_cnt, r.dly);
      end
      st_cnt = 0;
      if (r.v) begin
        m_cnt++;
        if (r.ctl[CTL_LD_FLAGS]) m_eflags = r.flags;
      end
    end
  end

  initial begin
    int idx, tail, req_cyc;
    bub = mk(0, 9'd0, 9'd0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    vecs.push_back(mk(0, 9'b000000100, 9'd0, 0, 0, 0, 32'h81, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk(1, 9'b000000100, 9'd0, 0, 0, 0, 32'h81, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk(1, 9'b100000100, {3'd3, 3'd0, 3'd0}, 32'h12345678, 32'h11, 32'h22, 32'h44, 0, 0, 0, 3'b001, 0));
    vecs.push_back(mk(1, 9'b010001000, {3'd0, 3'd2, 3'd0}, 32'hDEADBEEF, 32'h0B, 32'h0C, 0, 32'h1000, 0, 3, 3'b010, 0));
    vecs.push_back(mk(1, 9'b001110000, {3'd5, 3'd1, 3'd7}, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h77, 0, 0,
                      64'h0123_4567_89AB_CDEF, 0, 3'b100, 0));
    vecs.push_back(mk(1, 9'b000001000, 9'd0, 32'hCAFEF00D, 0, 0, 0, 32'h2000, 0, 0, 3'b000, 0));
    vecs.push_back(mk(1, 9'b000001100, 9'd0, 32'h13572468, 0, 0, 32'h801, 32'h2004, 0, 1, 3'b000, 0));
    vecs.push_back(mk(1, 9'b000000011, 9'd0, 0, 0, 5, 32'h40, 0, 0, 0, 3'b000, 1));
    vecs.push_back(mk(1, 9'b000000011, 9'd0, 0, 0, 0, 32'h0, 0, 0, 0, 3'b000, 1));
    vecs.push_back(mk(1, 9'b000000011, 9'd0, 0, 0, 5, 32'h0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk(1, 9'b000000001, 9'd0, 0, 0, 0, 32'h0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk(0, 9'b000000011, 9'd0, 0, 0, 0, 32'h40, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk(1, 9'b111000000, {3'd1, 3'd2, 3'd4}, 32'h1, 32'h2, 32'h3, 0, 0, 0, 0, 3'b111, 0));
    CLR = 1'b1;
    dcache_wr_ack = 1'b0;
    apply(bub);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    chk("rst_req", {63'd0, dcache_wr_req}, 64'd0);
    chk("rst_stall", {63'd0, WB_Stall}, 64'd0);
    chk("rst_eflags", {32'd0, eflags}, 64'h2);
    chk("rst_cnt", {32'd0, retired_count}, 64'd0);
    chk("rst_gpr_we", {61'd0, gpr_we}, 64'd0);
    apply(mk(1, 9'b000001000, 9'd0, 32'h55AA55AA, 0, 0, 0, 32'h3000, 0, 0, 3'b000, 0));
    @(negedge CLK);
    #1;
    chk("pre_clr_req", {63'd0, dcache_wr_req}, 64'd1);
    chk("pre_clr_stall", {63'd0, WB_Stall}, 64'd1);
    chk("pre_clr_addr", {32'd0, dcache_wr_addr}, 64'h3000);
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    chk("clr_req_gated", {63'd0, dcache_wr_req}, 64'd0);
    chk("clr_stall_gated", {63'd0, WB_Stall}, 64'd0);
    @(negedge CLK);
    dcache_wr_ack = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    apply(bub);
    #1;
    chk("post_clr_req", {63'd0, dcache_wr_req}, 64'd0);
    chk("post_clr_stall", {63'd0, WB_Stall}, 64'd0);
    chk("post_clr_eflags", {32'd0, eflags}, 64'h2);
    chk("post_clr_cnt", {32'd0, retired_count}, 64'd0);
    @(negedge CLK);
    dcache_wr_ack = 1'b0;
    #1;
    chk("late_ack_cnt", {32'd0, retired_count}, 64'd0);
    chk("late_ack_req", {63'd0, dcache_wr_req}, 64'd0);
    m_eflags = 32'h2;
    m_cnt = 0;
    sb.push_back(bub);
    mon_en = 1'b1;
    idx = 0;
    tail = 0;
    req_cyc = 0;
    for (int cyc = 0; cyc < 400 && tail < 3; cyc++) begin
      @(negedge CLK);
      dcache_wr_ack = dcache_wr_req && dq.size() > 0 && req_cyc == dq[0];
      #1;
      if (!WB_Stall) begin
        if (idx < vecs.size()) begin
          apply(vecs[idx]);
          sb.push_back(vecs[idx]);
          if (vecs[idx].v && vecs[idx].ctl[CTL_DCACHE_WRITE]) dq.push_back(vecs[idx].dly);
          idx++;
        end else begin
          apply(bub);
          sb.push_back(bub);
          tail++;
        end
      end
      if (dcache_wr_ack) begin
        void'(dq.pop_front());
        req_cyc = 0;
      end else if (dcache_wr_req) req_cyc++;
    end
    @(posedge CLK);
    mon_en = 1'b0;
    chk("all_issued", idx, vecs.size());
    chk("drain", sb.size(), 1);
    chk("acks_done", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
